// File: rtl/alu_share_arbiter_pkg.sv
// Shared ALU port types, operation codes and arbiter state encoding.
// Imported by the arbiter top and its round-robin picker.
package alu_share_arbiter_pkg;
   localparam int DATA_W = 32;
   localparam int OPER_W = 4;

   typedef enum logic [OPER_W-1:0] {
      AluAdd  = 4'd0,
      AluSub  = 4'd1,
      AluAnd  = 4'd2,
      AluOr   = 4'd3,
      AluXor  = 4'd4,
      AluSll  = 4'd5,
      AluSrl  = 4'd6,
      AluSra  = 4'd7,
      AluSlts = 4'd8,
      AluSltu = 4'd9
   } AluOper;

   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      AluOper            oper;
   } PortIn_Alu;

   typedef struct packed {
      logic [DATA_W-1:0] data;
   } PortOut_Alu;

   // Latched request; deliberately the same layout as PortIn_Alu.
   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      AluOper            oper;
   } PortIn_AluReq;

   typedef enum logic [1:0] {
      ArbIdle = 2'd0,
      ArbExec = 2'd1,
      ArbResp = 2'd2
   } ArbState;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/alu_share_arbiter_rr_picker.sv
// Combinational round-robin pick: first valid requester at or after rr_ptr, wrapping.
// Zero latency; no state, no backpressure of its own.
module alu_rr_picker
   import alu_share_arbiter_pkg::*;
#(
   parameter  int NUM_REQ = 2,
   localparam int IDX_W   = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);
   int cand;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      cand  = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = int'(rr_ptr) + k;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         if (!any && valid[cand]) begin
            grant[cand] = 1'b1;
            idx         = IDX_W'(cand);
            any         = 1'b1;
         end
      end
   end
endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one external combinational ALU; accept at edge N -> rsp_valid from N+2.
// Holds rsp_data and blocks all new requests until the owner takes the result.
module alu_share_arbiter
   import alu_share_arbiter_pkg::*;
#(
   parameter  int NUM_REQ = 2,
   localparam int IDX_W   = idx_width(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      flush,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*DATA_W-1:0] req_a,
   input  logic [NUM_REQ*DATA_W-1:0] req_b,
   input  logic [NUM_REQ*OPER_W-1:0] req_oper,
   output PortIn_Alu                 alu_in,
   input  PortOut_Alu                alu_out,
   output logic [NUM_REQ-1:0]        rsp_valid,
   input  logic [NUM_REQ-1:0]        rsp_ready,
   output logic [DATA_W-1:0]         rsp_data
);
   ArbState           state_q, state_d;
   logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]  owner_q, owner_d;
   PortIn_AluReq      op_q, op_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

   logic [NUM_REQ-1:0] pick_grant;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_any;

   alu_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
      .valid  (req_valid),
      .rr_ptr (rr_ptr_q),
      .grant  (pick_grant),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      owner_d    = owner_q;
      op_d       = op_q;
      rsp_data_d = rsp_data_q;
      req_ready  = '0;
      rsp_valid  = '0;
      case (state_q)
         ArbIdle: begin
            if (!flush && pick_any) begin
               req_ready = pick_grant;
               owner_d   = pick_idx;
               op_d.a    = req_a[DATA_W*int'(pick_idx) +: DATA_W];
               op_d.b    = req_b[DATA_W*int'(pick_idx) +: DATA_W];
               op_d.oper = AluOper'(req_oper[OPER_W*int'(pick_idx) +: OPER_W]);
               state_d   = ArbExec;
            end
         end
         ArbExec: begin
            if (flush) begin
               state_d = ArbIdle;
            end else begin
               rsp_data_d = alu_out.data;
               state_d    = ArbResp;
            end
         end
         ArbResp: begin
            rsp_valid[owner_q] = 1'b1;
            // Flush wins over a same-cycle handshake so the owner keeps its priority.
            if (flush) begin
               state_d = ArbIdle;
            end else if (rsp_ready[owner_q]) begin
               rr_ptr_d = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
               state_d  = ArbIdle;
            end
         end
         default: state_d = ArbIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ArbIdle;
         rr_ptr_q   <= '0;
         owner_q    <= '0;
         op_q       <= '0;
         rsp_data_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         owner_q    <= owner_d;
         op_q       <= op_d;
         rsp_data_q <= rsp_data_d;
      end
   end

   assign alu_in   = '{a: op_q.a, b: op_q.b, oper: op_q.oper};
   assign rsp_data = rsp_data_q;
endmodule
